// File: rtl/adc_model_pkg.sv
// Shared constants, FSM state type and LFSR step for the ADC128S052 responder.
package adc_model_pkg;

  localparam int ADC_CHANNELS    = 8;
  localparam int ADC_BITS        = 12;
  localparam int ADDR_BITS       = 3;
  localparam int FRAME_BITS      = 16;
  localparam int ADDR_FIRST_EDGE = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } adc_model_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    if (v[0]) begin
      lfsr_next = (v >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr_next = v >> 1;
    end
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, with single-clk rise/fall pulses
// derived from the synchronized copy.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_sync;
    end
  end

  assign o_rise = w_sync & ~r_prev;
  assign o_fall = ~w_sync & r_prev;

endmodule

// File: rtl/adc128s052_responder.sv
// Slave-side ADC128S052 model: returns ch[conv_addr] over dout, captures the next address from din.
// Optional build macro ADC_MODEL_NOISE_EN perturbs the low NOISE_BITS of each loaded sample.
module adc128s052_responder
  import adc_model_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NOISE_BITS  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cs,
  input  logic                             sclk,
  input  logic                             din_bit,
  input  logic [ADC_CHANNELS*ADC_BITS-1:0] ch_data,
  output logic                             dout_bit,
  output logic                             frame_done,
  output logic                             frame_err,
  output logic [ADDR_BITS-1:0]             conv_addr,
  output logic [15:0]                      frame_cnt
);

  localparam logic [ADC_BITS-1:0] NOISE_MASK = ADC_BITS'((1 << NOISE_BITS) - 1);

  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_din;
  logic [ADC_BITS-1:0]    w_ch_sel;
  logic [ADC_BITS-1:0]    w_noise;
  logic [ADC_BITS-1:0]    w_load;

  logic [SYNC_STAGES-1:0] r_din_sync;
  adc_model_state_t       r_state;
  logic [4:0]             r_bit_cnt;
  // Holds result bits 14..0; bit 15 is always 0 and is driven directly at load
  logic [FRAME_BITS-2:0]  r_dout_sr;
  logic [ADDR_BITS-1:0]   r_addr_sr;
  logic                   r_dout_bit;
  logic                   r_frame_done;
  logic                   r_frame_err;
  logic [ADDR_BITS-1:0]   r_conv_addr;
  logic [15:0]            r_frame_cnt;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(cs),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // din only needs a level; same depth keeps it aligned with the sclk rise pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], din_bit};
    end
  end

  assign w_din    = r_din_sync[SYNC_STAGES-1];
  assign w_ch_sel = ch_data[int'(r_conv_addr)*ADC_BITS +: ADC_BITS];

`ifdef ADC_MODEL_NOISE_EN
  logic [15:0] r_lfsr;

  // LFSR steps once per frame load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if ((r_state == IDLE) && w_cs_rise) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  assign w_noise = r_lfsr[ADC_BITS-1:0];
`else
  assign w_noise = {ADC_BITS{1'b0}};
`endif

  assign w_load = w_ch_sel ^ (w_noise & NOISE_MASK);

  // Frame FSM: load on cs rise, count/sample on sclk rise, shift on sclk fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 5'd0;
      r_dout_sr    <= {(FRAME_BITS-1){1'b0}};
      r_addr_sr    <= {ADDR_BITS{1'b0}};
      r_dout_bit   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_conv_addr  <= {ADDR_BITS{1'b0}};
      r_frame_cnt  <= 16'd0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_dout_bit <= 1'b0;
          if (w_cs_rise) begin
            r_dout_sr <= {3'b000, w_load};
            r_bit_cnt <= 5'd0;
            r_state   <= ACTIVE;
          end else begin
            r_state <= IDLE;
          end
        end
        ACTIVE: begin
          if (w_sclk_rise && (r_bit_cnt == 5'(FRAME_BITS - 1))) begin
            // A cs fall in the same clk still completes the frame
            r_bit_cnt    <= 5'(FRAME_BITS);
            r_frame_done <= 1'b1;
            r_conv_addr  <= r_addr_sr;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
            r_dout_bit   <= 1'b0;
            r_state      <= w_cs_fall ? IDLE : DONE;
          end else if (w_cs_fall) begin
            r_frame_err <= 1'b1;
            r_dout_bit  <= 1'b0;
            r_state     <= IDLE;
          end else if (w_sclk_rise) begin
            if (r_bit_cnt < 5'(FRAME_BITS)) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end else begin
              r_bit_cnt <= r_bit_cnt;
            end
            if ((r_bit_cnt >= 5'(ADDR_FIRST_EDGE)) &&
                (r_bit_cnt < 5'(ADDR_FIRST_EDGE + ADDR_BITS))) begin
              r_addr_sr <= {r_addr_sr[ADDR_BITS-2:0], w_din};
            end else begin
              r_addr_sr <= r_addr_sr;
            end
          end else if (w_sclk_fall) begin
            r_dout_bit <= r_dout_sr[FRAME_BITS-2];
            r_dout_sr  <= {r_dout_sr[FRAME_BITS-3:0], 1'b0};
          end else begin
            r_state <= ACTIVE;
          end
        end
        DONE: begin
          r_dout_bit <= 1'b0;
          if (w_cs_fall) begin
            r_state <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_dout_bit <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign dout_bit   = r_dout_bit;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign conv_addr  = r_conv_addr;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_adc128s052_responder.sv
// Directed and randomized frames against a frame-level model of the ADC128S052 responder.
module tb_adc128s052_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        sclk = 1'b0;
  logic        din_bit = 1'b0;
  logic [95:0] ch_data = 96'd0;
  logic        dout_bit;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  conv_addr;
  logic [15:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_rise = 0;
  int rise_no = 0;

  // Reference model state: channel values, address for next conversion, frame count
  logic [11:0] m_ch [8];
  logic [2:0]  m_addr;
  logic [15:0] m_cnt;

  adc128s052_responder #(.SYNC_STAGES(2), .NOISE_BITS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .sclk      (sclk),
    .din_bit   (din_bit),
    .ch_data   (ch_data),
    .dout_bit  (dout_bit),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .conv_addr (conv_addr),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // pulse monitor: record how many done/err pulses and which rise a done pulse followed
  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt  = done_cnt + 1;
      done_rise = rise_no;
    end
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_ch();
    for (int i = 0; i < 8; i++) ch_data[12*i +: 12] = m_ch[i];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"},  {31'd0, dout_bit},   32'd0);
    check({tag, "_done"},  {31'd0, frame_done}, 32'd0);
    check({tag, "_err"},   {31'd0, frame_err},  32'd0);
    check({tag, "_addr"},  {29'd0, conv_addr},  32'd0);
    check({tag, "_cnt"},   {16'd0, frame_cnt},  32'd0);
  endtask

  // Drive one frame of n sclk cycles; dout is sampled just before each rise
  task automatic run_frame(input logic [2:0] addr, input int n, input bit scramble,
                           output logic [31:0] rd);
    rd = 32'd0;
    sclk = 1'b0;
    cs = 1'b1;
    rise_no = 0;
    repeat (6) @(posedge clk);
    #1;
    if (scramble) ch_data = {$urandom, $urandom, $urandom};
    for (int k = 1; k <= n; k++) begin
      if (k >= 3 && k <= 5) din_bit = addr[5-k];
      else din_bit = 1'($urandom);
      repeat (6) @(posedge clk);
      #1;
      rd = {rd[30:0], dout_bit};
      sclk = 1'b1;
      rise_no = k;
      repeat (6) @(posedge clk);
      #1;
      sclk = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    cs = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input logic [2:0] addr, input int n, input bit scramble, input string tag);
    logic [15:0] exp_word;
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic [31:0] mask;
    int          done0;
    int          err0;
    exp_word = {4'h0, m_ch[m_addr]};
    done0 = done_cnt;
    err0  = err_cnt;
    run_frame(addr, n, scramble, rd);
    exp_rd = 32'd0;
    mask   = 32'd0;
    for (int k = 1; k <= n; k++) begin
      exp_rd = {exp_rd[30:0], (k <= 16) ? exp_word[16-k] : 1'b0};
`ifdef ADC_MODEL_NOISE_EN
      mask = {mask[30:0], (k == 15 || k == 16) ? 1'b0 : 1'b1};
`else
      mask = {mask[30:0], 1'b1};
`endif
    end
    check({tag, "_dout"}, rd & mask, exp_rd & mask);
    if (n >= 16) begin
      m_addr = addr;
      m_cnt  = m_cnt + 16'd1;
      check({tag, "_done_cnt"}, done_cnt - done0, 32'd1);
      check({tag, "_done_rise"}, done_rise, 32'd16);
      check({tag, "_err_cnt"}, err_cnt - err0, 32'd0);
    end else begin
      check({tag, "_done_cnt"}, done_cnt - done0, 32'd0);
      check({tag, "_err_cnt"}, err_cnt - err0, 32'd1);
    end
    check({tag, "_conv_addr"}, {29'd0, conv_addr}, {29'd0, m_addr});
    check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, {16'd0, m_cnt});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) m_ch[i] = 12'h000;
    m_addr = 3'd0;
    m_cnt  = 16'd0;
    apply_ch();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    m_ch[0] = 12'hABC;
    apply_ch();
    do_frame(3'b101, 16, 1'b0, "t1");

    m_ch[5] = 12'h123;
    apply_ch();
    do_frame(3'b010, 16, 1'b0, "t2");

    m_ch[2] = 12'h5A5;
    apply_ch();
    do_frame(3'b110, 9, 1'b0, "t3_abort");
    do_frame(3'b001, 16, 1'b0, "t3_next");

    m_ch[1] = 12'hF0F;
    apply_ch();
    do_frame(3'b011, 20, 1'b0, "t4");

    // reset asserted in the high phase after rise 7
    m_ch[3] = 12'h777;
    apply_ch();
    cs = 1'b1;
    repeat (6) @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      repeat (6) @(posedge clk);
      #1 sclk = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      if (k < 7) sclk = 1'b0;
    end
    rst_n = 1'b0;
    #2;
    check_reset_outputs("t5_rst");
    cs = 1'b0;
    sclk = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    m_addr = 3'd0;
    m_cnt  = 16'd0;
    repeat (4) @(posedge clk);
    #1;
    m_ch[0] = 12'h3C6;
    apply_ch();
    do_frame(3'b100, 16, 1'b0, "t5_after");

    m_ch[0] = 12'h800;
    m_ch[4] = 12'h800;
    apply_ch();
    for (int i = 0; i < 4; i++) do_frame(3'b000, 16, 1'b0, "t6");

    for (int i = 0; i < 25; i++) begin
      for (int c = 0; c < 8; c++) m_ch[c] = 12'($urandom);
      apply_ch();
      case ($urandom_range(0, 3))
        0: n = $urandom_range(1, 15);
        3: n = $urandom_range(17, 20);
        default: n = 16;
      endcase
      do_frame(3'($urandom), n, 1'b1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
